// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus and regfile write port of the hxd32 writeback arbiter.
// Requesters sit on the master side; the arbiter is the slave.
interface regfile_wr_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 3
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0][4:0]      req_addr;
    logic [NUM_REQ-1:0][XLEN-1:0] req_data;
    logic                         rd_wr_en;
    logic [4:0]                   rd_wr_addr;
    logic [XLEN-1:0]              rd_wr_data;
    logic [IW-1:0]                grant_idx;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rd_wr_en, rd_wr_addr, rd_wr_data, grant_idx
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rd_wr_en, rd_wr_addr, rd_wr_data, grant_idx
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NUM_REQ writeback sources.
// Optional REGFILE_WR_ARB_BYPASS_EN adds rs1/rs2 forwarding of the pending write.
module regfile_wr_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
`ifdef REGFILE_WR_ARB_BYPASS_EN
    input  logic [4:0]           rs1_rd_addr_i,
    input  logic [4:0]           rs2_rd_addr_i,
    input  logic [XLEN-1:0]      rs1_rd_data_i,
    input  logic [XLEN-1:0]      rs2_rd_data_i,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
`endif
    regfile_wr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [IW:0]        scan;
    logic [IW-1:0]      idx;

    logic               wr_en_q;
    logic [4:0]         wr_addr_q;
    logic [XLEN-1:0]    wr_data_q;
    logic [IW-1:0]      grant_idx_q;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        scan    = '0;
        idx     = '0;
        if (!rst_i && !flush_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (IW+1)'(k);
                if (scan >= (IW+1)'(NUM_REQ))
                    scan = scan - (IW+1)'(NUM_REQ);
                idx = scan[IW-1:0];
                if (!gnt_any && bus.req_valid[idx]) begin
                    gnt_any  = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_idx_q <= '0;
            rr_ptr      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (gnt_any) begin
                wr_en_q     <= (bus.req_addr[gnt_idx] != 5'd0);
                wr_addr_q   <= bus.req_addr[gnt_idx];
                wr_data_q   <= bus.req_data[gnt_idx];
                grant_idx_q <= gnt_idx;
                rr_ptr      <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    // Masking with rst_i keeps a held write from landing on the reset edge itself.
    assign bus.req_ready  = gnt;
    assign bus.rd_wr_en   = wr_en_q & ~rst_i;
    assign bus.rd_wr_addr = wr_addr_q;
    assign bus.rd_wr_data = wr_data_q;
    assign bus.grant_idx  = grant_idx_q;

`ifdef REGFILE_WR_ARB_BYPASS_EN
    assign rs1_data_o = (bus.rd_wr_en && wr_addr_q == rs1_rd_addr_i && rs1_rd_addr_i != 5'd0)
                        ? wr_data_q : rs1_rd_data_i;
    assign rs2_data_o = (bus.rd_wr_en && wr_addr_q == rs2_rd_addr_i && rs2_rd_addr_i != 5'd0)
                        ? wr_data_q : rs2_rd_data_i;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural regfile on the write port.
module tb_regfile_wr_arbiter;
    logic clk, rst, flush, rf_clr;
    int   checks = 0;
    int   failures = 0;

    regfile_wr_arbiter_if #(.XLEN(32), .NUM_REQ(3)) bus ();

    logic [31:0] rf [32];

`ifdef REGFILE_WR_ARB_BYPASS_EN
    logic [4:0]  rs1_rd_addr, rs2_rd_addr;
    logic [31:0] rs1_rd_data, rs2_rd_data, rs1_data, rs2_data;
    assign rs1_rd_data = rf[rs1_rd_addr];
    assign rs2_rd_data = rf[rs2_rd_addr];
`endif

    regfile_wr_arbiter #(.XLEN(32), .NUM_REQ(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
`ifdef REGFILE_WR_ARB_BYPASS_EN
        .rs1_rd_addr_i (rs1_rd_addr),
        .rs2_rd_addr_i (rs2_rd_addr),
        .rs1_rd_data_i (rs1_rd_data),
        .rs2_rd_data_i (rs2_rd_data),
        .rs1_data_o    (rs1_data),
        .rs2_data_o    (rs2_data),
`endif
        .bus           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int k = 0; k < 32; k++) rf[k] <= '0;
        end else if (bus.rd_wr_en) begin
            rf[bus.rd_wr_addr] <= bus.rd_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] rr_data [3];

    initial begin
        rr_data[0] = 32'hA0;
        rr_data[1] = 32'hB1;
        rr_data[2] = 32'hC2;

        // Reset held two edges with every requester valid
        rst = 1'b1; flush = 1'b0; rf_clr = 1'b1;
        bus.req_valid = 3'b111;
        bus.req_addr[0] = 5'd1; bus.req_data[0] = 32'h100;
        bus.req_addr[1] = 5'd2; bus.req_data[1] = 32'h200;
        bus.req_addr[2] = 5'd3; bus.req_data[2] = 32'h300;
        tick();
        chk("rst_ready",  32'(bus.req_ready), 32'h0);
        tick();
        chk("rst_ready2", 32'(bus.req_ready), 32'h0);
        chk("rst_wr_en",  32'(bus.rd_wr_en),  32'h0);
        chk("rst_gidx",   32'(bus.grant_idx), 32'h0);
        rst = 1'b0; rf_clr = 1'b0;
        settle();
        chk("first_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 3'b000;
        tick();
        chk("idle_wr_en", 32'(bus.rd_wr_en), 32'h0);

        // Single source: req1 -> x5
        bus.req_valid = 3'b010; bus.req_addr[1] = 5'd5; bus.req_data[1] = 32'h15;
        settle();
        chk("single_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 3'b000;
        chk("single_en",   32'(bus.rd_wr_en),   32'h1);
        chk("single_addr", 32'(bus.rd_wr_addr), 32'd5);
        chk("single_data", bus.rd_wr_data,      32'h15);
        chk("single_gidx", 32'(bus.grant_idx),  32'h1);
        tick();
        chk("single_en_off", 32'(bus.rd_wr_en),  32'h0);
        chk("single_gidx_h", 32'(bus.grant_idx), 32'h1);
        chk("rf_x5",         rf[5],              32'h15);

        // req2 alone brings rr_ptr back to 0, then all three compete
        bus.req_valid = 3'b100; bus.req_addr[2] = 5'd12; bus.req_data[2] = rr_data[2];
        settle();
        chk("rr_pre_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 3'b111;
        bus.req_addr[0] = 5'd10; bus.req_data[0] = rr_data[0];
        bus.req_addr[1] = 5'd11; bus.req_data[1] = rr_data[1];
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 3)));
            tick();
            chk("rr_gidx", 32'(bus.grant_idx),  32'(c % 3));
            chk("rr_addr", 32'(bus.rd_wr_addr), 32'(10 + c % 3));
            chk("rr_data", bus.rd_wr_data,      rr_data[c % 3]);
        end
        bus.req_valid = 3'b000;
        tick();
        chk("rf_x10", rf[10], 32'hA0);
        chk("rf_x11", rf[11], 32'hB1);
        chk("rf_x12", rf[12], 32'hC2);

        // x0 write: acked, dropped, pointer advances
        bus.req_valid = 3'b001; bus.req_addr[0] = 5'd0; bus.req_data[0] = 32'hDEADBEEF;
        settle();
        chk("x0_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 3'b000;
        chk("x0_en",   32'(bus.rd_wr_en),  32'h0);
        chk("x0_gidx", 32'(bus.grant_idx), 32'h0);
        chk("x0_data", bus.rd_wr_data,     32'hDEADBEEF);
        tick();
        chk("rf_x0", rf[0], 32'h0);
        bus.req_valid = 3'b111;
        settle();
        chk("x0_rr_adv", 32'(bus.req_ready), 32'h2);

        // Flush blocks req2 and leaves rr_ptr at 1
        bus.req_valid = 3'b100; flush = 1'b1;
        bus.req_addr[2] = 5'd20; bus.req_data[2] = 32'h777;
        settle();
        chk("flush_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("flush_en", 32'(bus.rd_wr_en), 32'h0);
        flush = 1'b0; bus.req_valid = 3'b111;
        settle();
        chk("flush_rr_hold", 32'(bus.req_ready), 32'h2);

        // Handshake followed by reset: write to x21 must be discarded
        bus.req_valid = 3'b010; bus.req_addr[1] = 5'd21; bus.req_data[1] = 32'h999;
        settle();
        chk("pre_rst_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("pre_rst_en",   32'(bus.rd_wr_en),   32'h1);
        chk("pre_rst_addr", 32'(bus.rd_wr_addr), 32'd21);
        rst = 1'b1; bus.req_valid = 3'b111;
        settle();
        chk("midrst_en",    32'(bus.rd_wr_en),  32'h0);
        chk("midrst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        chk("rf_x21",       rf[21],              32'h0);
        chk("midrst_gidx",  32'(bus.grant_idx),  32'h0);
        chk("midrst_addr",  32'(bus.rd_wr_addr), 32'h0);
        rst = 1'b0;
        settle();
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);

        // Write x7 and read it in the cycle it sits in the output stage
        bus.req_valid = 3'b001; bus.req_addr[0] = 5'd7; bus.req_data[0] = 32'h23;
`ifdef REGFILE_WR_ARB_BYPASS_EN
        rs1_rd_addr = 5'd7; rs2_rd_addr = 5'd8;
`endif
        settle();
        tick();
        bus.req_valid = 3'b000;
        settle();
`ifdef REGFILE_WR_ARB_BYPASS_EN
        chk("byp_rs1", rs1_data, 32'h23);
        chk("byp_rs2", rs2_data, 32'h0);
`else
        chk("nobyp_old_x7", rf[7], 32'h0);
`endif
        tick();
        chk("rf_x7", rf[7], 32'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
